// File: rtl/recog_pkg.sv
// ---------------------------------------------------------------------------
// recog_pkg
//   Shared definitions for the gesture recognition core: default SRAM
//   geometry, requester index constants for the core_mem arbiter and the
//   arbiter state encoding.
//
//   Contents:
//     ADDR_W_DEF / DATA_W_DEF   default SRAM word address / data widths
//     NUM_REQ_DEF               default number of core_mem requesters
//     WAIT_MAX_DEF              default stall limit before an access aborts
//     LOCK_MAX                  longest burst lock before a forced rotation
//     REQ_RECORD / REQ_RESAMPLE / REQ_RECOGNIZE   requester indices
//     arb_state_e               arbiter FSM states
// ---------------------------------------------------------------------------
package recog_pkg;

    localparam int ADDR_W_DEF   = 20;
    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REQ_DEF  = 3;
    localparam int WAIT_MAX_DEF = 1023;
    localparam int LOCK_MAX     = 64;

    localparam int REQ_RECORD    = 0;
    localparam int REQ_RESAMPLE  = 1;
    localparam int REQ_RECOGNIZE = 2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_RESP
    } arb_state_e;

endpackage : recog_pkg

// File: rtl/core_mem_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin picker. Searches the request vector starting
//   one position after the pointer (wrapping modulo N) and returns the first
//   set bit as a one-hot grant and as a binary index.
//
//   Ports:
//     i_req    in   N       request vector
//     i_ptr    in   IDX_W   index of the most recent grant
//     o_gnt    out  N       one-hot grant (all zero when nothing requests)
//     o_idx    out  IDX_W   binary index of the granted requester
//     o_valid  out  1       at least one request is set
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // NOTE: every variable assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        int cand;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        cand    = 0;
        // The pointer itself is visited last, so the previous winner has
        // the lowest priority in this round.
        for (int off = 1; off <= N; off++) begin
            cand = int'(i_ptr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!o_valid && i_req[cand]) begin
                o_valid     = 1'b1;
                o_gnt[cand] = 1'b1;
                o_idx       = IDX_W'(cand);
            end
        end
    end

endmodule : rr_picker

// File: rtl/core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// core_mem_arbiter
//   Shares the single core_mem SRAM port between the record writer (0), the
//   resampler (1) and the recognizer (2) with round-robin arbitration. One
//   access is outstanding at a time; the command is held stable across
//   core_wait stalls and completion is reported with a one-cycle one-hot ack.
//   An access stalled for WAIT_MAX consecutive cycles is aborted and acked
//   with o_err.
//
//   Optional feature (macro ARB_BURST_LOCK_EN): adds i_lock. A requester that
//   holds i_lock and i_req while being acked is regranted immediately,
//   bypassing rotation, for up to LOCK_MAX consecutive grants.
//
//   Ports:
//     i_clk, i_rst_n      clock, asynchronous active-low reset
//     i_req / i_wr        per-requester request (held until ack) / write flag
//     i_addr / i_wdata    packed per-requester address / write data
//     i_lock              per-requester burst lock (ARB_BURST_LOCK_EN only)
//     o_ack               one-hot, one-cycle completion pulse
//     o_rdata / o_err     read data / timeout flag, valid with o_ack
//     o_busy              access in flight (ISSUE or RESP)
//     core_mem_*          SRAM command and read data
//     core_wait           SRAM stall
// ---------------------------------------------------------------------------
module core_mem_arbiter
    import recog_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
`ifdef ARB_BURST_LOCK_EN
    input  logic [NUM_REQ-1:0]        i_lock,
`endif
    output logic [NUM_REQ-1:0]        o_ack,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_err,
    output logic                      o_busy,
    input  logic [DATA_W-1:0]         core_mem_r_value,
    output logic [DATA_W-1:0]         core_mem_w_value,
    output logic [ADDR_W-1:0]         core_mem_addr,
    output logic                      core_mem_wr,
    output logic                      core_mem_request,
    input  logic                      core_wait
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    localparam logic [IDX_W-1:0]  PTR_RESET = IDX_W'(NUM_REQ - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_MAX - 1);
    localparam logic [WCNT_W-1:0] WCNT_SAT  = WCNT_W'(WAIT_MAX);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  grant_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    logic [NUM_REQ-1:0] sel_gnt;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_wr;

    logic               abort;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_gnt   (pick_gnt),
        .o_idx   (pick_idx),
        .o_valid (pick_valid)
    );

    // -----------------------------------------------------------------------
    // Grant selection: rotation result, optionally overridden by a burst lock
    // -----------------------------------------------------------------------
`ifdef ARB_BURST_LOCK_EN
    localparam int BURST_W = $clog2(LOCK_MAX + 1);

    logic               lock_q;
    logic [BURST_W-1:0] burst_q;
    logic               use_lock;
    logic [NUM_REQ-1:0] lock_gnt;

    // The lock only takes effect if the locked requester still asks.
    assign use_lock = lock_q && i_req[grant_q];

    always_comb begin
        lock_gnt          = '0;
        lock_gnt[grant_q] = 1'b1;
    end

    assign sel_gnt   = use_lock ? lock_gnt : pick_gnt;
    assign sel_idx   = use_lock ? grant_q  : pick_idx;
    assign sel_valid = use_lock || pick_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_q  <= 1'b0;
            burst_q <= '0;
        end else if (state_q == ARB_IDLE && sel_valid) begin
            lock_q  <= 1'b0;
            burst_q <= use_lock ? burst_q + 1'b1 : BURST_W'(1);
        end else if (state_q == ARB_RESP) begin
            // A burst that already reached LOCK_MAX grants goes through one
            // normal rotation before it can lock again.
            lock_q <= i_lock[grant_q] && i_req[grant_q] &&
                      (burst_q < BURST_W'(LOCK_MAX));
        end
    end
`else
    assign sel_gnt   = pick_gnt;
    assign sel_idx   = pick_idx;
    assign sel_valid = pick_valid;
`endif

    // One-hot AND-OR mux of the winning requester's command.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_gnt[k]) begin
                sel_addr  = sel_addr  | i_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | i_wdata[k*DATA_W +: DATA_W];
                sel_wr    = sel_wr    | i_wr[k];
            end
        end
    end

    // The edge that records the WAIT_MAX-th stall also ends the access.
    assign abort = core_wait && (wcnt_q == WCNT_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (sel_valid) state_d = ARB_ISSUE;
            ARB_ISSUE: if (!core_wait || abort) state_d = ARB_RESP;
            ARB_RESP:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        o_ack          = '0;
        o_ack[grant_q] = (state_q == ARB_RESP);
        o_rdata        = (state_q == ARB_RESP) ? rdata_q : '0;
        o_err          = (state_q == ARB_RESP) && err_q;
        o_busy         = (state_q != ARB_IDLE);
    end

    // -----------------------------------------------------------------------
    // Datapath: command latch, stall counter, response capture
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q            <= PTR_RESET;
            grant_q          <= '0;
            wcnt_q           <= '0;
            err_q            <= 1'b0;
            rdata_q          <= '0;
            core_mem_addr    <= '0;
            core_mem_w_value <= '0;
            core_mem_wr      <= 1'b0;
            core_mem_request <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (sel_valid) begin
                        core_mem_addr    <= sel_addr;
                        core_mem_w_value <= sel_wdata;
                        core_mem_wr      <= sel_wr;
                        core_mem_request <= 1'b1;
                        grant_q          <= sel_idx;
                        ptr_q            <= sel_idx;
                        rdata_q          <= '0;
                        err_q            <= 1'b0;
                        wcnt_q           <= '0;
                    end
                end
                ARB_ISSUE: begin
                    if (!core_wait) begin
                        core_mem_request <= 1'b0;
                        rdata_q          <= core_mem_wr ? '0 : core_mem_r_value;
                    end else begin
                        if (wcnt_q != WCNT_SAT) begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                        if (abort) begin
                            core_mem_request <= 1'b0;
                            err_q            <= 1'b1;
                            rdata_q          <= '0;
                        end
                    end
                end
                ARB_RESP: begin
                    wcnt_q <= '0;
                    err_q  <= 1'b0;
                end
                default: begin
                    core_mem_request <= 1'b0;
                end
            endcase
        end
    end

endmodule : core_mem_arbiter

// File: tb/tb_core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_core_mem_arbiter
//   Scoreboard bench for core_mem_arbiter. Stimulus pushes the expected SRAM
//   command and the expected ack into queues; a monitor on the falling edge
//   pops and compares whenever the DUT starts a command or pulses o_ack.
//   WAIT_MAX is reduced to 8 so the timeout path is short.
// ---------------------------------------------------------------------------
module tb_core_mem_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 16;
    localparam int WAIT_MAX = 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } ack_t;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        wr;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
`ifdef ARB_BURST_LOCK_EN
    logic [NUM_REQ-1:0]        lock;
`endif
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      err;
    logic                      busy;
    logic [DATA_W-1:0]         r_value;
    logic [DATA_W-1:0]         w_value;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_wr;
    logic                      mem_request;
    logic                      mem_wait;

    cmd_t cmd_q[$];
    ack_t ack_q[$];
    cmd_t cur_cmd;
    bit   in_cmd;

    int checks;
    int errors;

    core_mem_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req            (req),
        .i_wr             (wr),
        .i_addr           (addr),
        .i_wdata          (wdata),
`ifdef ARB_BURST_LOCK_EN
        .i_lock           (lock),
`endif
        .o_ack            (ack),
        .o_rdata          (rdata),
        .o_err            (err),
        .o_busy           (busy),
        .core_mem_r_value (r_value),
        .core_mem_w_value (w_value),
        .core_mem_addr    (mem_addr),
        .core_mem_wr      (mem_wr),
        .core_mem_request (mem_request),
        .core_wait        (mem_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor: command stability and ack scoreboard
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst_n) begin
            in_cmd = 1'b0;
        end else begin
            if (mem_request) begin
                if (!in_cmd) begin
                    if (cmd_q.size() == 0) begin
                        check("cmd_unexpected", 32'd1, 32'd0);
                    end else begin
                        cur_cmd = cmd_q.pop_front();
                        in_cmd  = 1'b1;
                    end
                end
                if (in_cmd) begin
                    check("cmd_addr",  32'(mem_addr), 32'(cur_cmd.addr));
                    check("cmd_wr",    32'(mem_wr),   32'(cur_cmd.wr));
                    check("cmd_wdata", 32'(w_value),  32'(cur_cmd.wdata));
                end
            end else begin
                in_cmd = 1'b0;
            end

            if (ack != '0) begin
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    ack_t e;
                    e = ack_q.pop_front();
                    check("ack_onehot", 32'(ack),   32'd1 << e.idx);
                    check("ack_rdata",  32'(rdata), 32'(e.rdata));
                    check("ack_err",    32'(err),   32'(e.err));
                    check("ack_busy",   32'(busy),  32'd1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic set_req(input int idx, input bit w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        wr[idx]                  = w;
        addr[idx*ADDR_W +: ADDR_W] = a;
        wdata[idx*DATA_W +: DATA_W] = d;
        req[idx]                 = 1'b1;
    endtask

    task automatic push_exp(input int idx, input bit w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rd,
                            input bit e);
        cmd_t c;
        ack_t k;
        c.addr = a;  c.wr = w;  c.wdata = d;
        k.idx = idx; k.rdata = rd; k.err = e;
        cmd_q.push_back(c);
        ack_q.push_back(k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        mem_wait = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Single access with nwait stall edges; latency counted from the cycle the
    // request is raised (cycle 0) to the cycle o_ack is seen.
    task automatic do_access(input string tag, input int idx, input bit w,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [DATA_W-1:0] rv, input int nwait,
                             input bit exp_err, input int exp_lat, input int exp_req_cyc);
        bit done;
        int req_cyc;
        push_exp(idx, w, a, d, (w || exp_err) ? '0 : rv, exp_err);
        @(negedge clk);
        set_req(idx, w, a, d);
        r_value  = rv;
        mem_wait = 1'b0;
        done     = 1'b0;
        req_cyc  = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (mem_request) req_cyc++;
            if (ack[idx]) begin
                done = 1'b1;
                check({tag, "_latency"},  32'(c),       32'(exp_lat));
                check({tag, "_req_cycles"}, 32'(req_cyc), 32'(exp_req_cyc));
                req[idx] = 1'b0;
                mem_wait = 1'b0;
            end else begin
                mem_wait = (c <= nwait);
            end
        end
        if (!done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            req[idx] = 1'b0;
        end
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        checks   = 0;
        errors   = 0;
        in_cmd   = 1'b0;
        rst_n    = 1'b0;
        req      = '0;
        wr       = '0;
        addr     = '0;
        wdata    = '0;
        r_value  = '0;
        mem_wait = 1'b0;
`ifdef ARB_BURST_LOCK_EN
        lock     = '0;
`endif
        #1;
        check("reset_request", 32'(mem_request), 32'd0);
        check("reset_ack",     32'(ack),         32'd0);
        check("reset_busy",    32'(busy),        32'd0);
        check("reset_addr",    32'(mem_addr),    32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Single read, zero wait.
        do_access("read0", 0, 1'b0, 20'h00010, 16'h0000, 16'hBEEF, 0, 1'b0, 2, 1);
        // Write stalled 5 cycles at the top address.
        do_access("wait5", 0, 1'b1, 20'hFFFFF, 16'h1234, 16'h5555, 5, 1'b0, 7, 6);
        // One stall short of the limit still completes.
        do_access("wait7", 2, 1'b0, 20'h00005, 16'h0000, 16'h0077, 7, 1'b0, 9, 8);
        // Stuck wait: abort after WAIT_MAX stall edges, read data forced to 0.
        do_access("abort", 1, 1'b0, 20'h00123, 16'h0000, 16'hAAAA, 100, 1'b1, 9, 8);
        // A plain access right after an abort is clean again.
        do_access("post_abort", 1, 1'b1, 20'h00124, 16'h4321, 16'h0000, 0, 1'b0, 2, 1);

        // Continuous writes from all three requesters: order 0,1,2,0,1,2.
        do_reset();
        begin
            int cnt [NUM_REQ];
            int total;
            for (int j = 0; j < 2; j++) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    push_exp(k, 1'b1, 20'(32'h1000 * (k + 1) + j),
                             16'(32'hA000 + k * 16 + j), '0, 1'b0);
                end
            end
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt[k] = 0;
                set_req(k, 1'b1, 20'(32'h1000 * (k + 1)), 16'(32'hA000 + k * 16));
            end
            total = 0;
            for (int c = 0; c < 60 && total < 6; c++) begin
                @(negedge clk);
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (ack[k]) begin
                        cnt[k]++;
                        total++;
                        if (cnt[k] == 2) begin
                            req[k] = 1'b0;
                        end else begin
                            addr[k*ADDR_W +: ADDR_W]  = 20'(32'h1000 * (k + 1) + cnt[k]);
                            wdata[k*DATA_W +: DATA_W] = 16'(32'hA000 + k * 16 + cnt[k]);
                        end
                    end
                end
            end
            check("rr_total_acks", 32'(total), 32'd6);
            req = '0;
        end

        // Async reset in the middle of a stalled access.
        begin
            cmd_t c;
            c.addr = 20'h00ABC; c.wr = 1'b0; c.wdata = 16'h0000;
            cmd_q.push_back(c);
            @(negedge clk);
            set_req(0, 1'b0, 20'h00ABC, 16'h0000);
            mem_wait = 1'b1;
            repeat (3) @(negedge clk);
            check("mid_issue_request", 32'(mem_request), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            check("rst_async_request", 32'(mem_request), 32'd0);
            check("rst_async_addr",    32'(mem_addr),    32'd0);
            check("rst_async_wr",      32'(mem_wr),      32'd0);
            check("rst_async_wvalue",  32'(w_value),     32'd0);
            check("rst_async_ack",     32'(ack),         32'd0);
            check("rst_async_busy",    32'(busy),        32'd0);
            check("rst_async_err",     32'(err),         32'd0);
            check("rst_async_rdata",   32'(rdata),       32'd0);
            req      = '0;
            mem_wait = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
        end

        // After reset, requesters 1 and 2 together: 1 wins first.
        begin
            int total;
            push_exp(1, 1'b1, 20'h00201, 16'h0B01, '0, 1'b0);
            push_exp(2, 1'b1, 20'h00302, 16'h0C02, '0, 1'b0);
            @(negedge clk);
            set_req(1, 1'b1, 20'h00201, 16'h0B01);
            set_req(2, 1'b1, 20'h00302, 16'h0C02);
            total = 0;
            for (int c = 0; c < 30 && total < 2; c++) begin
                @(negedge clk);
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (ack[k]) begin
                        req[k] = 1'b0;
                        total++;
                    end
                end
            end
            check("post_reset_acks", 32'(total), 32'd2);
            req = '0;
        end

`ifdef ARB_BURST_LOCK_EN
        // Locked resampler bursts 64 grants, then rotation resumes: 2, then 0.
        do_reset();
        begin
            int total;
            int cnt1;
            for (int j = 0; j < 64; j++) push_exp(1, 1'b1, 20'h00400, 16'h0101, '0, 1'b0);
            push_exp(2, 1'b1, 20'h00500, 16'h0202, '0, 1'b0);
            push_exp(0, 1'b1, 20'h00600, 16'h0303, '0, 1'b0);
            @(negedge clk);
            set_req(1, 1'b1, 20'h00400, 16'h0101);
            lock[1] = 1'b1;
            @(negedge clk);
            set_req(2, 1'b1, 20'h00500, 16'h0202);
            set_req(0, 1'b1, 20'h00600, 16'h0303);
            total = 0;
            cnt1  = 0;
            for (int c = 0; c < 400 && total < 66; c++) begin
                @(negedge clk);
                if (ack != '0) total++;
                if (ack[1]) cnt1++;
            end
            check("lock_total_acks", 32'(total), 32'd66);
            check("lock_grants_req1", 32'(cnt1), 32'd64);
            req  = '0;
            lock = '0;
        end
`endif

        repeat (4) @(negedge clk);
        check("cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
        check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_core_mem_arbiter
